weight_fifo: RTL
================

WEIGHT_FIFO -- requirements
Module: weight_fifo

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose parameter DATA_W, default 8, bit width of one weight element.
REQ-002 The block SHALL expose parameter ROW_ELEMS, default 32, weights per row; row width RW = DATA_W*ROW_ELEMS (256).
REQ-003 The block SHALL expose parameter DEPTH, default 64, row capacity; power of two and at least 2*ROW_ELEMS (two tiles).
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of contents.
- wr_en_i  in  1  write request from weight memory.
- wr_data_i  in  RW  weight row to store.
- rd_en_i  in  1  read request; driven by control load_weights.
- rd_data_o  out  RW  registered read row.
- valid_o  out  1  rd_data_o holds a newly read row.
- tile_rdy_o  out  1  count >= ROW_ELEMS; feeds control fifo_full_i.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- count_o  out  log2(DEPTH)+1  rows stored.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

Function
REQ-005 Storage SHALL be a DEPTH x RW circular buffer with write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-006 Write accept: wr_en_i && !full_o SHALL store wr_data_i at wp and increment wp at that edge.
REQ-007 Write while full SHALL be dropped (no pointer or data change) and set overflow_o, even with a simultaneous accepted read.
REQ-008 Read accept: rd_en_i && !empty_o SHALL load mem[rp] into rd_data_o and increment rp at that edge; valid_o SHALL be 1 in the following cycle (1-cycle latency).
REQ-009 Read while empty SHALL be dropped, drive valid_o 0 next cycle, leave rd_data_o unchanged, and set underflow_o.
REQ-010 valid_o SHALL be 0 in every cycle not following an accepted read; rd_data_o SHALL hold its last value while valid_o is 0.
REQ-011 count_o SHALL update at the same edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-012 Simultaneous accepted read and write with count 0 SHALL NOT occur (empty blocks read); the written row SHALL be readable no earlier than the next cycle (no write-to-read bypass).
REQ-013 full_o, empty_o, tile_rdy_o SHALL be decoded combinationally from registered count_o.
REQ-014 flush_i SHALL clear wp, rp, count_o, valid_o, overflow_o, underflow_o at the next edge and override wr_en_i/rd_en_i in that cycle; rd_data_o SHALL hold.
REQ-015 Back-to-back reads SHALL deliver one row per cycle with valid_o held continuously high; 32 consecutive reads from count >= 32 SHALL yield 32 consecutive valid cycles in write order.
REQ-016 overflow_o/underflow_o SHALL clear only on reset or flush_i.
REQ-017 Memory contents SHALL NOT require reset; no X SHALL reach rd_data_o from an unwritten location under legal use.

Reset
REQ-018 With rst_i low, asynchronously: wp=0, rp=0, count_o=0, valid_o=0, rd_data_o=0, overflow_o=0, underflow_o=0; hence empty_o=1, full_o=0, tile_rdy_o=0.
REQ-019 Reset asserted mid-transfer SHALL discard all stored rows; first accepted write after release SHALL land at address 0.
REQ-020 Outputs SHALL remain at reset values until the first rising clk_i edge after rst_i goes high.

Verification
REQ-021 Write 32 rows (row k = all elements k) -> tile_rdy_o rises in the cycle after the 32nd write edge, count_o=32, full_o=0.
REQ-022 From count 32, rd_en_i high 32 cycles -> valid_o high 32 consecutive cycles starting one cycle after the first read, rows 0..31 in order, then empty_o=1, tile_rdy_o=0.
REQ-023 Fill to 64, one extra write -> count_o stays 64, overflow_o=1; extra write plus read same cycle -> count_o=63, overflow_o stays 1.
REQ-024 Wrap: write 64, read 40, write 40 -> count_o=64, next 64 reads return rows 40..63 then the 40 new rows in order.
REQ-025 Read when empty -> valid_o=0, underflow_o=1; flush_i with count 20 -> count_o=0, flags 0 next edge, concurrent wr_en_i ignored.
REQ-026 rst_i low asynchronously between clock edges at count 17 -> all outputs at reset values immediately; post-release write then read returns the new row.

Source files
------------

// File: rtl/weight_fifo.sv
// Row-wide circular FIFO that buffers weight rows between weight memory and the array loader.
// Registered read port, sticky overflow/underflow flags, and a tile-ready threshold flag.
module weight_fifo #(
  parameter int DATA_W    = 8,
  parameter int ROW_ELEMS = 32,
  parameter int DEPTH     = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W*ROW_ELEMS-1:0]   wr_data_i,
  input  logic                          rd_en_i,
  output logic [DATA_W*ROW_ELEMS-1:0]   rd_data_o,
  output logic                          valid_o,
  output logic                          tile_rdy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int RW = DATA_W * ROW_ELEMS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_acc;
  logic          rd_acc;

  // Handshake: a request is taken at a rising edge when its enable is high and the
  // FIFO is not full (write) / not empty (read); a taken read presents its row on
  // rd_data_o with valid_o high for exactly the next cycle. Refused requests are
  // dropped and only raise the sticky flag. flush_i suppresses both requests.
  assign full_o     = (count_o == CW'(DEPTH));
  assign empty_o    = (count_o == '0);
  assign tile_rdy_o = (count_o >= CW'(ROW_ELEMS));

  assign wr_acc = wr_en_i && !full_o && !flush_i;
  assign rd_acc = rd_en_i && !empty_o && !flush_i;

  // Storage carries no reset; only written locations are ever read back.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wp] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp          <= '0;
      rp          <= '0;
      count_o     <= '0;
      valid_o     <= 1'b0;
      rd_data_o   <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wp          <= '0;
      rp          <= '0;
      count_o     <= '0;
      valid_o     <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      valid_o <= rd_acc;
      if (wr_acc) wp <= wp + 1'b1;
      if (rd_acc) begin
        rp        <= rp + 1'b1;
        rd_data_o <= mem[rp];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
      if (wr_en_i && full_o)  overflow_o  <= 1'b1;
      if (rd_en_i && empty_o) underflow_o <= 1'b1;
    end
  end

endmodule
